mem_access_unit: RTL and testbench

//  MEM-stage data-memory access unit. Consumes the EX/MEM register outputs:

---
 rtl/mem_pkg.sv | 34 +++
 rtl/mem_load_ext.sv | 33 +++
 rtl/mem_access_unit.sv | 162 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage data-memory access unit:
// access codes, bus size codes, FSM state encoding.
package mem_pkg;

  localparam logic [2:0] FC_LB  = 3'b000;
  localparam logic [2:0] FC_LBU = 3'b001;
  localparam logic [2:0] FC_LH  = 3'b010;
  localparam logic [2:0] FC_LHU = 3'b011;
  localparam logic [2:0] FC_LW  = 3'b100;
  localparam logic [2:0] FC_SB  = 3'b101;
  localparam logic [2:0] FC_SH  = 3'b110;
  localparam logic [2:0] FC_SW  = 3'b111;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_DONE
  } mem_state_e;

  // Bus transfer size implied by an access code.
  function automatic logic [1:0] fc_size(input logic [2:0] fc);
    case (fc)
      FC_LB, FC_LBU, FC_SB: return SZ_BYTE;
      FC_LH, FC_LHU, FC_SH: return SZ_HALF;
      default:              return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Load lane select and sign/zero extension (purely combinational).
module mem_load_ext
  import mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  logic [2:0]  fc_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Pick the addressed byte/half, then extend according to the access code.
  always_comb begin
    case (addr_i)
      2'd0:    byte_v = rdata_i[7:0];
      2'd1:    byte_v = rdata_i[15:8];
      2'd2:    byte_v = rdata_i[23:16];
      default: byte_v = rdata_i[31:24];
    endcase
    half_v = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (fc_i)
      FC_LB:   data_o = {{24{byte_v[7]}}, byte_v};
      FC_LBU:  data_o = {24'h0, byte_v};
      FC_LH:   data_o = {{16{half_v[15]}}, half_v};
      FC_LHU:  data_o = {16'h0, half_v};
      FC_LW:   data_o = rdata_i;
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: one req/addr_ok/data_ok transaction
// per load or store, store lane alignment, load extension, alignment
// exceptions and a pipeline stall until the access completes.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter logic ADDR_CHK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM2,
  input  logic        memtoregM,
  input  logic        memwriteM,
  input  logic [2:0]  fcM,
  input  logic        flushM,
  input  logic        stallW,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic [31:0] readdataM,
  output logic        mem_stallM,
  output logic        adelM,
  output logic        adesM
);

  mem_state_e  state_q;
  logic        discard_q;
  logic [31:0] rbuf_q;
  // Request fields captured at issue so the bus stays stable even if the
  // EX/MEM register is squashed while the request is still outstanding.
  logic        wr_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [3:0]  wstrb_q;
  logic [31:0] wdata_q;
  logic [2:0]  fc_q;

  logic [1:0]  size_c;
  logic        mis_c;
  logic        access_c;
  logic        idle_c;
  logic        drop_c;
  logic [3:0]  wstrb_c;
  logic [31:0] wdata_c;
  logic [31:0] ext_src;

  assign size_c   = fc_size(fcM);
  assign mis_c    = ((size_c == SZ_HALF) & aluoutM[0]) |
                    ((size_c == SZ_WORD) & (|aluoutM[1:0]));
  assign adelM    = ADDR_CHK & ~rst & memtoregM & mis_c;
  assign adesM    = ADDR_CHK & ~rst & memwriteM & mis_c;
  assign access_c = (memtoregM | memwriteM) & ~adelM & ~adesM;
  assign idle_c   = (state_q == ST_IDLE);
  // A flush arriving together with data_ok still kills the response.
  assign drop_c   = discard_q | flushM;

  // Store lane replication and byte enables; loads drive no strobes.
  always_comb begin
    wstrb_c = 4'b0000;
    wdata_c = writedataM2;
    if (memwriteM) begin
      case (size_c)
        SZ_BYTE: begin
          wstrb_c = 4'b0001 << aluoutM[1:0];
          wdata_c = {4{writedataM2[7:0]}};
        end
        SZ_HALF: begin
          wstrb_c = aluoutM[1] ? 4'b1100 : 4'b0011;
          wdata_c = {2{writedataM2[15:0]}};
        end
        default: wstrb_c = 4'b1111;
      endcase
    end
  end

  assign data_req   = ~rst & (idle_c ? (access_c & ~flushM) : (state_q == ST_ADDR));
  assign data_wr    = idle_c ? memwriteM : wr_q;
  assign data_size  = idle_c ? size_c    : size_q;
  assign data_addr  = idle_c ? aluoutM   : addr_q;
  assign data_wstrb = idle_c ? wstrb_c   : wstrb_q;
  assign data_wdata = idle_c ? wdata_c   : wdata_q;

  // Hold IF..MEM while a request waits for acceptance or its response.
  always_comb begin
    mem_stallM = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_IDLE: mem_stallM = data_req;
        ST_ADDR: mem_stallM = 1'b1;
        ST_DATA: mem_stallM = ~data_data_ok;
        default: mem_stallM = 1'b0;
      endcase
    end
  end

  // Transaction FSM, response buffer and squash tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      discard_q <= 1'b0;
      rbuf_q    <= 32'h0;
      wr_q      <= 1'b0;
      size_q    <= SZ_BYTE;
      addr_q    <= 32'h0;
      wstrb_q   <= 4'h0;
      wdata_q   <= 32'h0;
      fc_q      <= FC_LB;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (data_req) begin
            wr_q    <= memwriteM;
            size_q  <= size_c;
            addr_q  <= aluoutM;
            wstrb_q <= wstrb_c;
            wdata_q <= wdata_c;
            fc_q    <= fcM;
            state_q <= data_addr_ok ? ST_DATA : ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (flushM)       discard_q <= 1'b1;
          if (data_addr_ok) state_q   <= ST_DATA;
        end
        ST_DATA: begin
          if (data_data_ok) begin
            if (drop_c) begin
              discard_q <= 1'b0;
              state_q   <= ST_IDLE;
            end else begin
              rbuf_q  <= data_rdata;
              state_q <= stallW ? ST_DONE : ST_IDLE;
            end
          end else if (flushM) begin
            discard_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (!stallW) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ext_src = ((state_q == ST_DATA) && data_data_ok) ? data_rdata : rbuf_q;

  mem_load_ext u_ext (
    .rdata_i (ext_src),
    .addr_i  (idle_c ? aluoutM[1:0] : addr_q[1:0]),
    .fc_i    (idle_c ? fcM : fc_q),
    .data_o  (readdataM)
  );

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: reactive SRAM-like slave, expected-request
// scoreboard, load-result monitor, directed cases plus a randomized run.
module tb_mem_access_unit;

  localparam logic [2:0] LB = 3'd0, LBU = 3'd1, LH = 3'd2, LW = 3'd4, SH = 3'd6, SW = 3'd7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] aluoutM = 32'h0, writedataM2 = 32'h0;
  logic        memtoregM = 1'b0, memwriteM = 1'b0, flushM = 1'b0, stallW = 1'b0;
  logic [2:0]  fcM = 3'd0;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, readdataM;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok = 1'b0, data_data_ok = 1'b0;
  logic [31:0] data_rdata = 32'h0;
  logic        mem_stallM, adelM, adesM;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_CHK(1'b1)) dut (
    .clk(clk), .rst(rst), .aluoutM(aluoutM), .writedataM2(writedataM2),
    .memtoregM(memtoregM), .memwriteM(memwriteM), .fcM(fcM), .flushM(flushM),
    .stallW(stallW), .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .readdataM(readdataM), .mem_stallM(mem_stallM), .adelM(adelM), .adesM(adesM)
  );

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [2:0]  fc;
  } req_t;

  req_t        exp_q[$];
  req_t        infl;
  int          checks = 0, errors = 0;
  int          ao_delay = 0, do_delay = 0, cnt = 0, ao_cnt = 0;
  bit          pend = 0, rd_force = 0, cur_flushed = 0, mon_chk = 0;
  logic [31:0] rd_val = 32'h0, last_rdata = 32'h0, mon_exp = 32'h0, cap_rd = 32'h0;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_wstrb;
  logic [1:0]  cap_size;
  logic        cap_wr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: access code -> size, request fields, extended load value.
  function automatic logic [1:0] m_size(input logic [2:0] fc);
    if (fc == 3'd0 || fc == 3'd1 || fc == 3'd5) return 2'd0;
    if (fc == 3'd2 || fc == 3'd3 || fc == 3'd6) return 2'd1;
    return 2'd2;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] fc, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] b, h;
    b = (rd >> (int'(a[1:0]) * 8)) & 32'hFF;
    h = (rd >> (int'(a[1]) * 16)) & 32'hFFFF;
    case (fc)
      3'd0:    return (b >= 32'd128)   ? b - 32'd256     : b;
      3'd1:    return b;
      3'd2:    return (h >= 32'd32768) ? h - 32'h10000   : h;
      3'd3:    return h;
      default: return rd;
    endcase
  endfunction

  function automatic req_t m_req(input logic [2:0] fc, input logic [31:0] a, input logic [31:0] wd);
    req_t r;
    r.wr = (fc >= 3'd5); r.size = m_size(fc); r.addr = a; r.fc = fc;
    r.wstrb = 4'h0; r.wdata = wd;
    if (fc == 3'd5) begin
      r.wstrb = 4'(1 << a[1:0]);
      r.wdata = {24'h0, wd[7:0]} * 32'h01010101;
    end else if (fc == 3'd6) begin
      r.wstrb = a[1] ? 4'b1100 : 4'b0011;
      r.wdata = {16'h0, wd[15:0]} * 32'h00010001;
    end else if (fc == 3'd7) begin
      r.wstrb = 4'b1111;
    end
    return r;
  endfunction

  // Slave: checks every request against the scoreboard head (also proves the
  // request stays stable while waiting), grants addr_ok and returns data_ok.
  always @(negedge clk) begin
    req_t r;
    bit   ok;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata   = $urandom;
    mon_chk      = 1'b0;
    if (rst) begin
      pend = 0; ao_cnt = 0; last_rdata = 32'h0;
    end else begin
      if (pend) begin
        if (cnt == 0) begin
          data_data_ok = 1'b1;
          data_rdata   = rd_force ? rd_val : $urandom;
          pend         = 0;
          mon_chk      = !infl.wr && !cur_flushed;
          mon_exp      = m_load(infl.fc, infl.addr, data_rdata);
          if (!cur_flushed) last_rdata = data_rdata;
        end else cnt--;
      end
      if (data_req) begin
        if (exp_q.size() == 0 || pend) chk("req_unexpected", data_req, 1'b0);
        else begin
          r = exp_q[0];
          chk("req_wr", data_wr, r.wr);
          chk("req_size", data_size, r.size);
          chk("req_addr", data_addr, r.addr);
          chk("req_wstrb", data_wstrb, r.wstrb);
          if (r.wr) chk("req_wdata", data_wdata, r.wdata);
          ok = (ao_delay < 0) ? ($urandom % 3 != 0) : (ao_cnt >= ao_delay);
          if (ok) begin
            data_addr_ok = 1'b1;
            ao_cnt = 0;
            infl = exp_q.pop_front();
            pend = 1;
            cnt  = (do_delay < 0) ? $urandom_range(0, 2) : do_delay;
          end else ao_cnt++;
        end
      end
    end
  end

  // Monitor: load result and stall release on every response.
  always begin
    @(negedge clk); #1;
    if (!rst && data_data_ok) begin
      cap_rd = readdataM;
      chk("stall_on_data_ok", mem_stallM, 1'b0);
      if (mon_chk) chk("load_data", readdataM, mon_exp);
    end
  end

  task automatic do_op(input logic [2:0] fc, input logic [31:0] a, input logic [31:0] wd,
                       input int hold_w, output int stalls);
    req_t        r;
    bit          mis;
    logic [31:0] e;
    r   = m_req(fc, a, wd);
    mis = (int'(a[1:0]) % (1 << r.size)) != 0;
    @(posedge clk); #1;
    fcM = fc; aluoutM = a; writedataM2 = wd;
    memtoregM = (fc < 3'd5); memwriteM = (fc >= 3'd5);
    stallW = (hold_w > 0); flushM = 1'b0; cur_flushed = 0;
    if (!mis) exp_q.push_back(r);
    stalls = 0;
    @(negedge clk); #2;
    cap_wstrb = data_wstrb; cap_wdata = data_wdata; cap_size = data_size; cap_wr = data_wr;
    if (mis) begin
      chk("mis_adel", adelM, !r.wr);
      chk("mis_ades", adesM, r.wr);
      chk("mis_req", data_req, 1'b0);
      chk("mis_stall", mem_stallM, 1'b0);
      return;
    end
    chk("aligned_no_exc", adelM | adesM, 1'b0);
    while (mem_stallM && stalls < 60) begin
      stalls++;
      @(negedge clk); #2;
    end
    if (mem_stallM) chk("op_timeout", mem_stallM, 1'b0);
    if (hold_w > 0) begin
      e = m_load(fc, a, last_rdata);
      for (int i = 0; i < hold_w; i++) begin
        @(negedge clk); #2;
        chk("done_stall", mem_stallM, 1'b0);
        chk("done_req", data_req, 1'b0);
        if (!r.wr) chk("done_hold", readdataM, e);
      end
      @(posedge clk); #1 stallW = 1'b0;
      @(negedge clk); #2;
      chk("done_release_stall", mem_stallM, 1'b0);
      if (!r.wr) chk("done_release_data", readdataM, e);
    end
  endtask

  initial begin
    int st, n;
    logic [2:0]  fc;
    logic [31:0] a;
    int          hw;

    // Reset: a misaligned load is presented but nothing may come out.
    memtoregM = 1'b1; fcM = LW; aluoutM = 32'h1002;
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    chk("rst_req", data_req, 1'b0);
    chk("rst_stall", mem_stallM, 1'b0);
    chk("rst_adel", adelM, 1'b0);
    chk("rst_ades", adesM, 1'b0);
    chk("rst_rbuf", readdataM, 32'h0);
    @(posedge clk); #1 rst = 1'b0; memtoregM = 1'b0; aluoutM = 32'h1000;
    @(negedge clk); #2;
    chk("idle_req", data_req, 1'b0);
    chk("idle_stall", mem_stallM, 1'b0);

    // Best case word load.
    ao_delay = 0; do_delay = 0; rd_force = 1; rd_val = 32'hDEADBEEF;
    do_op(LW, 32'h1000, 32'h0, 0, st);
    chk("lw_stall_cycles", st, 1);
    chk("lw_data", cap_rd, 32'hDEADBEEF);

    rd_val = 32'h80FFFFFF;
    do_op(LB, 32'h1003, 32'h0, 0, st);
    chk("lb_data", cap_rd, 32'hFFFFFF80);
    do_op(LBU, 32'h1003, 32'h0, 0, st);
    chk("lbu_data", cap_rd, 32'h00000080);

    do_op(SH, 32'h2002, 32'h1234ABCD, 0, st);
    chk("sh_wstrb", cap_wstrb, 4'b1100);
    chk("sh_wdata", cap_wdata, 32'hABCDABCD);
    chk("sh_size", cap_size, 2'd1);
    chk("sh_wr", cap_wr, 1'b1);

    do_op(LW, 32'h3002, 32'h0, 0, st);
    do_op(SW, 32'h3001, 32'h0, 0, st);
    do_op(LH, 32'h3001, 32'h0, 0, st);

    // addr_ok three cycles late, stallW held over the response.
    ao_delay = 3; rd_val = 32'h13579BDF;
    do_op(LW, 32'h4000, 32'h0, 3, st);
    chk("slow_addr_stalls", st, 4);

    // Flush while waiting for addr_ok: request held, response dropped.
    ao_delay = 3; do_delay = 1; rd_force = 0;
    @(posedge clk); #1;
    fcM = LW; aluoutM = 32'h5000; memtoregM = 1'b1; memwriteM = 1'b0;
    stallW = 1'b0; flushM = 1'b0; cur_flushed = 0;
    exp_q.push_back(m_req(LW, 32'h5000, writedataM2));
    @(negedge clk); #2;
    chk("flush_pre_req", data_req, 1'b1);
    @(posedge clk); #1;
    flushM = 1'b1; cur_flushed = 1; memtoregM = 1'b0; aluoutM = $urandom; fcM = 3'($urandom);
    @(negedge clk); #2;
    chk("flush_req_held", data_req, 1'b1);
    chk("flush_stall_held", mem_stallM, 1'b1);
    @(posedge clk); #1 flushM = 1'b0;
    n = 0;
    do begin
      @(negedge clk); #2; n++;
    end while (mem_stallM && n < 40);
    chk("flush_timeout", mem_stallM, 1'b0);
    @(posedge clk); #1 fcM = LW; aluoutM = 32'h5004;
    @(negedge clk); #2;
    chk("flush_idle_req", data_req, 1'b0);
    chk("flush_idle_stall", mem_stallM, 1'b0);
    chk("flush_rbuf_kept", readdataM, last_rdata);
    chk("flush_q_empty", exp_q.size(), 0);
    cur_flushed = 0;

    // Reset while waiting for data_ok.
    ao_delay = 0; do_delay = 5;
    @(posedge clk); #1;
    fcM = LW; aluoutM = 32'h6000; memtoregM = 1'b1;
    exp_q.push_back(m_req(LW, 32'h6000, writedataM2));
    @(negedge clk); #2;
    chk("rstdata_req", data_req, 1'b1);
    @(negedge clk); #2;
    chk("rstdata_in_data", mem_stallM, 1'b1);
    @(posedge clk); #1 rst = 1'b1; aluoutM = 32'h6002;
    @(negedge clk); #2;
    chk("rstdata_req_off", data_req, 1'b0);
    chk("rstdata_stall_off", mem_stallM, 1'b0);
    chk("rstdata_adel_off", adelM, 1'b0);
    @(posedge clk); #1 rst = 1'b0; memtoregM = 1'b0; aluoutM = 32'h6000;
    @(negedge clk); #2;
    chk("post_rst_req", data_req, 1'b0);
    chk("post_rst_stall", mem_stallM, 1'b0);
    chk("post_rst_rbuf", readdataM, 32'h0);

    // Randomized traffic with random slave timing.
    ao_delay = -1; do_delay = -1; rd_force = 0;
    for (int k = 0; k < 120; k++) begin
      fc = 3'($urandom);
      a  = $urandom;
      if ($urandom % 4 != 0) a = a & ~((32'd1 << m_size(fc)) - 32'd1);
      hw = ($urandom % 4 == 0) ? $urandom_range(1, 3) : 0;
      do_op(fc, a, $urandom, hw, st);
    end

    @(posedge clk); #1 memtoregM = 1'b0; memwriteM = 1'b0; stallW = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    chk("final_q_empty", exp_q.size(), 0);
    chk("final_stall", mem_stallM, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1);
  end

endmodule
